// File: rtl/ddr_readout_scheduler_pkg.sv
// Shared types and defaults for the DDR readout scheduler.
// Optional feature macro: DDR_SCHED_TIMEOUT_EN (drain timeout abort).
package ddr_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StGap
    } sched_state_e;

    localparam int unsigned DefNch     = 4;
    localparam int unsigned DefGapCyc  = 4;
    localparam int unsigned DefTimeout = 65535;
    localparam int unsigned DefCntW    = 16;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_readout_scheduler_if.sv
// Request/grant bundle between the memory FIFOs and the readout scheduler.
// master: scheduler side; slave: FIFO/datapath side.
interface ddr_readout_scheduler_if
    import ddr_sched_pkg::*;
#(
    parameter int unsigned NCH   = DefNch,
    parameter int unsigned CNT_W = DefCntW
);
    localparam int unsigned ChW = chan_w(NCH);

    logic             enable_i;
    logic [NCH-1:0]   fifo_full_i;
    logic [NCH-1:0]   fifo_empty_i;
    logic             ddr3_full_i;
    logic [NCH-1:0]   grant_o;
    logic [ChW-1:0]   chan_o;
    logic             data_valid;
    logic [CNT_W-1:0] blk_cnt_o;
    logic             timeout_o;

    modport master (
        input  enable_i, fifo_full_i, fifo_empty_i, ddr3_full_i,
        output grant_o, chan_o, data_valid, blk_cnt_o, timeout_o
    );

    modport slave (
        output enable_i, fifo_full_i, fifo_empty_i, ddr3_full_i,
        input  grant_o, chan_o, data_valid, blk_cnt_o, timeout_o
    );

endinterface

// File: rtl/ddr_readout_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after `last`, modulo NCH.
module rr_arbiter
    import ddr_sched_pkg::*;
#(
    parameter int unsigned NCH = DefNch
) (
    input  logic [NCH-1:0]              req_i,
    input  logic [chan_w(NCH)-1:0]      last_i,
    output logic [NCH-1:0]              gnt_o,
    output logic [chan_w(NCH)-1:0]      idx_o
);

    logic found;

    // Scan last+1 .. last+NCH and keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            int unsigned c;
            c = (32'(last_i) + k) % NCH;
            if (!found && req_i[c]) begin
                gnt_o[c] = 1'b1;
                idx_o    = chan_w(NCH)'(c);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_readout_scheduler.sv
// Round-robin owner of the shared DDR3 readout gate.
// Optional feature macro: DDR_SCHED_TIMEOUT_EN (abort a drain after TIMEOUT cycles).
module ddr_readout_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int unsigned NCH     = DefNch,
    parameter int unsigned GAP_CYC = DefGapCyc,
    parameter int unsigned TIMEOUT = DefTimeout,
    parameter int unsigned CNT_W   = DefCntW
) (
    input  logic                     clk,
    input  logic                     resetn_i,
    ddr_readout_scheduler_if.master  bus
);

    localparam int unsigned ChW  = chan_w(NCH);
    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    if (NCH < 2 || NCH > 16 || GAP_CYC < 1 || TIMEOUT < 2) begin : g_param_err
        $error("ddr_readout_scheduler: parameter out of range");
    end

    sched_state_e     state_q;
    logic [NCH-1:0]   grant_q;
    logic [ChW-1:0]   chan_q;
    logic [ChW-1:0]   last_q;
    logic             dv_q;
    logic [CNT_W-1:0] blk_q;
    logic [GapW-1:0]  gap_q;

    logic [NCH-1:0]   pick_gnt;
    logic [ChW-1:0]   pick_idx;
    logic             empty_sel;
    logic             start;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req_i  (bus.fifo_full_i),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    // Only the granted channel's empty flag can end a drain.
    assign empty_sel = bus.fifo_empty_i[chan_q];
    assign start     = bus.enable_i & ~bus.ddr3_full_i & (|bus.fifo_full_i);

`ifdef DDR_SCHED_TIMEOUT_EN
    localparam int unsigned TimeW = $clog2(TIMEOUT);
    logic [TimeW-1:0] drn_q;
    logic             to_q;

    // Drain-length watchdog; empty on the same edge wins over the abort.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            drn_q <= '0;
            to_q  <= 1'b0;
        end else begin
            to_q <= 1'b0;
            if (state_q == StIdle) begin
                drn_q <= '0;
            end else if (state_q == StDrain && !empty_sel) begin
                if (drn_q == TimeW'(TIMEOUT - 1)) begin
                    to_q <= 1'b1;
                end else begin
                    drn_q <= drn_q + TimeW'(1);
                end
            end
        end
    end

    logic abort;
    assign abort = (drn_q == TimeW'(TIMEOUT - 1)) & ~empty_sel;
    assign bus.timeout_o = to_q;
`else
    logic abort;
    assign abort = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    // Scheduler FSM with registered grant, gate and block counter.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            chan_q  <= '0;
            last_q  <= ChW'(NCH - 1);
            dv_q    <= 1'b0;
            blk_q   <= '0;
            gap_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StDrain;
                        grant_q <= pick_gnt;
                        chan_q  <= pick_idx;
                        last_q  <= pick_idx;
                        dv_q    <= 1'b1;
                    end
                end
                StDrain: begin
                    if (empty_sel || abort) begin
                        state_q <= StGap;
                        grant_q <= '0;
                        dv_q    <= 1'b0;
                        gap_q   <= '0;
                        if (empty_sel) begin
                            blk_q <= blk_q + CNT_W'(1);
                        end
                    end
                end
                StGap: begin
                    if (gap_q == GapW'(GAP_CYC - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.chan_o     = chan_q;
    assign bus.data_valid = dv_q;
    assign bus.blk_cnt_o  = blk_q;

endmodule
